// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_pkg
//  Description : Shared definitions for the sp_ram_sync single-port RAM:
//                read-during-write mode codes, clear-sequencer state
//                encoding and the byte-enable width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

  // Read-during-write behaviour selectors for READ_MODE
  localparam int RD_FIRST  = 0;  // dout returns the word before the write
  localparam int WR_FIRST  = 1;  // dout returns the merged, post-write word
  localparam int NO_CHANGE = 2;  // dout holds, no rvalid

  // Clear-sequencer states
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // One byte-enable bit per byte of the data word
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ram_init_seq
//  Description : Clear-on-reset sequencer. Walks o_clr_addr from 0 to
//                DEPTH-1, one word per clock, while o_busy is high; the
//                parent zeroes the addressed word on each of those clocks.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous active-high reset
//                o_busy     - clear in progress (state == CLEAR)
//                o_clr_addr - word currently being cleared
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int DEPTH          = 1024,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_addr;

  // A reset landing mid-clear restarts the walk from word 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      r_clr_addr <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          // Last word is written on this clock; leave CLEAR afterwards
          if (r_clr_addr == c_LAST_ADDR) begin
            r_state <= ST_READY;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        ST_READY: begin
          r_state <= ST_READY;
        end
      endcase
    end
  end

  assign o_busy     = (r_state == ST_CLEAR);
  assign o_clr_addr = r_clr_addr;

endmodule
`default_nettype wire

// File: rtl/sp_ram_sync.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram_sync
//  Description : Synchronous single-port RAM with byte-enabled writes,
//                registered read data with valid strobe, selectable
//                read-during-write mode, clear-on-reset and error strobe.
//  Ports       : clk, rst        - clock / async active-high reset
//                cs, rd, wr      - chip select, read and write requests
//                addr, be, din   - word address, byte enables, write data
//                dout, rvalid    - registered read data and its 1-cycle strobe
//                busy            - clear sequence running, accesses refused
//                err             - 1-cycle pulse on a refused access
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_sync
  import ram_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 10,
  parameter int DEPTH          = 1024,
  parameter int READ_MODE      = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cs,
  input  logic                          rd,
  input  logic                          wr,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [be_width(DATA_W)-1:0]   be,
  input  logic [DATA_W-1:0]             din,
  output logic [DATA_W-1:0]             dout,
  output logic                          rvalid,
  output logic                          busy,
  output logic                          err
);

  localparam int              c_BE_W  = be_width(DATA_W);
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_req;
  logic              w_oor;
  logic              w_refuse;
  logic              w_acc;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merged;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  ram_init_seq #(
    .ADDR_W         (ADDR_W),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_init_seq (
    .clk        (clk),
    .rst        (rst),
    .o_busy     (w_busy),
    .o_clr_addr (w_clr_addr)
  );

  // Access qualification: refused while clearing or beyond the array
  assign w_req    = cs & (rd | wr);
  assign w_oor    = ({1'b0, addr} >= c_DEPTH);
  assign w_refuse = w_req & (w_busy | w_oor);
  assign w_acc    = w_req & ~w_refuse;

  // Old word at the addressed location; only consumed when w_acc is set
  assign w_old = r_mem[addr];

  // Byte merge: enabled lanes take din, the rest keep the stored byte
  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < c_BE_W; i++) begin
      if (be[i]) begin
        w_merged[8*i +: 8] = din[8*i +: 8];
      end
    end
  end

  // Single write port shared between the clear sequencer and the bus
  always_comb begin
    w_we    = 1'b0;
    w_waddr = addr;
    w_wdata = w_merged;
    if (w_busy) begin
      w_we    = 1'b1;
      w_waddr = w_clr_addr;
      w_wdata = '0;
    end else if (w_acc & wr) begin
      w_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Read register, valid strobe and error strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout   <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      err    <= w_refuse;
      rvalid <= 1'b0;
      if (w_acc & rd) begin
        if (!wr) begin
          dout   <= w_old;
          rvalid <= 1'b1;
        end else if (READ_MODE == WR_FIRST) begin
          dout   <= w_merged;
          rvalid <= 1'b1;
        end else if (READ_MODE == RD_FIRST) begin
          dout   <= w_old;
          rvalid <= 1'b1;
        end
        // NO_CHANGE: dout holds and no strobe
      end
    end
  end

  assign busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sp_ram_sync
//  Description : Directed, table-driven bench for sp_ram_sync. A 32-bit,
//                1000-word read-first instance carries the main vectors;
//                8-bit instances cover write-first, no-change and the
//                no-clear configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_ram_sync;

  localparam int c_DEPTH = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance signals
  logic        cs, rd, wr;
  logic [9:0]  addr;
  logic [3:0]  be;
  logic [31:0] din;
  logic [31:0] dout;
  logic        rvalid, busy, err;

  // Shared stimulus for the 8-bit instances
  logic        s_cs, s_rd, s_wr;
  logic [3:0]  s_addr;
  logic [0:0]  s_be;
  logic [7:0]  s_din;
  logic [7:0]  m1_dout, m2_dout, m3_dout;
  logic        m1_rvalid, m2_rvalid, m3_rvalid;
  logic        m1_busy, m2_busy, m3_busy;
  logic        m1_err, m2_err, m3_err;

  sp_ram_sync #(.DATA_W(32), .ADDR_W(10), .DEPTH(c_DEPTH), .READ_MODE(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr), .addr(addr), .be(be), .din(din),
    .dout(dout), .rvalid(rvalid), .busy(busy), .err(err));

  sp_ram_sync #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .READ_MODE(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst(rst), .cs(s_cs), .rd(s_rd), .wr(s_wr), .addr(s_addr), .be(s_be), .din(s_din),
    .dout(m1_dout), .rvalid(m1_rvalid), .busy(m1_busy), .err(m1_err));

  sp_ram_sync #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .READ_MODE(2), .CLEAR_ON_RESET(1)) u2 (
    .clk(clk), .rst(rst), .cs(s_cs), .rd(s_rd), .wr(s_wr), .addr(s_addr), .be(s_be), .din(s_din),
    .dout(m2_dout), .rvalid(m2_rvalid), .busy(m2_busy), .err(m2_err));

  sp_ram_sync #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .READ_MODE(0), .CLEAR_ON_RESET(0)) u3 (
    .clk(clk), .rst(rst), .cs(s_cs), .rd(s_rd), .wr(s_wr), .addr(s_addr), .be(s_be), .din(s_din),
    .dout(m3_dout), .rvalid(m3_rvalid), .busy(m3_busy), .err(m3_err));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        cs, rd, wr;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] din;
    logic        exp_rv;
    logic        exp_err;
    logic [31:0] exp_dout;
  } vec_t;

  localparam int c_NVEC = 22;
  vec_t vecs [c_NVEC];

  function automatic vec_t mk(input logic c, input logic r, input logic w, input logic [9:0] a,
                              input logic [3:0] b, input logic [31:0] d, input logic erv,
                              input logic eerr, input logic [31:0] edout);
    vec_t v;
    v.cs = c; v.rd = r; v.wr = w; v.addr = a; v.be = b; v.din = d;
    v.exp_rv = erv; v.exp_err = eerr; v.exp_dout = edout;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; be = '0; din = '0;
  endtask

  task automatic s_drive(input logic r, input logic w, input logic [3:0] a,
                         input logic b, input logic [7:0] d);
    s_cs = 1'b1; s_rd = r; s_wr = w; s_addr = a; s_be = b; s_din = d;
  endtask

  initial begin
    int n;
    idle();
    s_cs = 1'b0; s_rd = 1'b0; s_wr = 1'b0; s_addr = '0; s_be = '0; s_din = '0;

    // ---- vector table (main instance, READY state, read-first) ----
    vecs[0]  = mk(1,1,0, 10'd0,    4'h0, 32'h0,        1,0, 32'h0);
    vecs[1]  = mk(1,1,0, 10'd511,  4'h0, 32'h0,        1,0, 32'h0);
    vecs[2]  = mk(1,1,0, 10'd999,  4'h0, 32'h0,        1,0, 32'h0);
    vecs[3]  = mk(1,1,0, 10'd299,  4'h0, 32'h0,        1,0, 32'h0);
    vecs[4]  = mk(1,1,0, 10'd2,    4'h0, 32'h0,        1,0, 32'h0);
    vecs[5]  = mk(1,0,1, 10'd5,    4'hF, 32'hAABBCCDD, 0,0, 32'h0);
    vecs[6]  = mk(1,0,1, 10'd5,    4'h5, 32'h11223344, 0,0, 32'h0);
    vecs[7]  = mk(1,1,0, 10'd5,    4'h0, 32'h0,        1,0, 32'hAA22CC44);
    vecs[8]  = mk(1,1,1, 10'd5,    4'h0, 32'hFFFFFFFF, 1,0, 32'hAA22CC44);
    vecs[9]  = mk(1,1,0, 10'd5,    4'h0, 32'h0,        1,0, 32'hAA22CC44);
    vecs[10] = mk(1,0,1, 10'd7,    4'hF, 32'h00000010, 0,0, 32'hAA22CC44);
    vecs[11] = mk(1,1,1, 10'd7,    4'hF, 32'h00000020, 1,0, 32'h00000010);
    vecs[12] = mk(1,1,0, 10'd7,    4'h0, 32'h0,        1,0, 32'h00000020);
    vecs[13] = mk(1,1,0, 10'd1000, 4'h0, 32'h0,        0,1, 32'h00000020);
    vecs[14] = mk(1,0,1, 10'd1000, 4'hF, 32'h99,       0,1, 32'h00000020);
    vecs[15] = mk(1,1,0, 10'd1023, 4'h0, 32'h0,        0,1, 32'h00000020);
    vecs[16] = mk(0,1,1, 10'd7,    4'hF, 32'h55,       0,0, 32'h00000020);
    vecs[17] = mk(1,0,0, 10'd7,    4'hF, 32'h55,       0,0, 32'h00000020);
    vecs[18] = mk(1,0,1, 10'd999,  4'hF, 32'h12345678, 0,0, 32'h00000020);
    vecs[19] = mk(1,1,0, 10'd999,  4'h0, 32'h0,        1,0, 32'h12345678);
    vecs[20] = mk(1,0,1, 10'd8,    4'h8, 32'hCDAB1234, 0,0, 32'h12345678);
    vecs[21] = mk(1,1,0, 10'd8,    4'h0, 32'h0,        1,0, 32'hCD000000);

    // ---- reset state ----
    step(); step();
    chk("reset dout",   dout, 32'h0);
    chk("reset rvalid", {31'b0, rvalid}, 32'h0);
    chk("reset err",    {31'b0, err}, 32'h0);
    chk("reset busy",   {31'b0, busy}, 32'h1);
    chk("noclear busy in reset", {31'b0, m3_busy}, 32'h0);

    // ---- accesses during clear are refused, back-to-back ----
    rst = 1'b0;
    cs = 1'b1; rd = 1'b1; addr = 10'd3;
    step();
    chk("busy read err",    {31'b0, err}, 32'h1);
    chk("busy read rvalid", {31'b0, rvalid}, 32'h0);
    cs = 1'b1; rd = 1'b0; wr = 1'b1; addr = 10'd299; be = 4'hF; din = 32'hDEADBEEF;
    step();
    chk("busy write err b2b", {31'b0, err}, 32'h1);
    idle();
    step();
    chk("err drops", {31'b0, err}, 32'h0);
    chk("noclear busy after reset", {31'b0, m3_busy}, 32'h0);

    // ---- reset mid-clear at cycle 300 ----
    for (int i = 3; i < 300; i++) step();
    chk("still busy at 300", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid-clear rst busy", {31'b0, busy}, 32'h1);
    chk("mid-clear rst dout", dout, 32'h0);
    step();
    rst = 1'b0;

    // ---- busy lasts exactly DEPTH cycles; a write on the last clear cycle is refused ----
    n = 0;
    do begin
      if (n == c_DEPTH - 1) begin
        cs = 1'b1; wr = 1'b1; addr = 10'd0; be = 4'hF; din = 32'hDEADBEEF;
      end
      step();
      n++;
      if (n == c_DEPTH) begin
        chk("last-clear write err", {31'b0, err}, 32'h1);
        chk("last-clear write rvalid", {31'b0, rvalid}, 32'h0);
      end
      idle();
    end while (busy && n < 1100);
    chk("busy cycle count", n, c_DEPTH);
    chk("busy low after clear", {31'b0, busy}, 32'h0);

    // ---- table-driven vectors ----
    for (int i = 0; i < c_NVEC; i++) begin
      cs = vecs[i].cs; rd = vecs[i].rd; wr = vecs[i].wr;
      addr = vecs[i].addr; be = vecs[i].be; din = vecs[i].din;
      step();
      chk($sformatf("vec%0d rvalid", i), {31'b0, rvalid}, {31'b0, vecs[i].exp_rv});
      chk($sformatf("vec%0d err", i),    {31'b0, err},    {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d dout", i),   dout,            vecs[i].exp_dout);
    end

    // ---- streaming: 16 writes then 16 reads, no bubbles ----
    for (int i = 0; i < 16; i++) begin
      cs = 1'b1; rd = 1'b0; wr = 1'b1; addr = 10'(i); be = 4'hF; din = 32'(i);
      step();
      chk($sformatf("stream wr%0d rvalid", i), {31'b0, rvalid}, 32'h0);
    end
    for (int i = 0; i < 16; i++) begin
      cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = 10'(i); be = 4'h0; din = 32'h0;
      step();
      chk($sformatf("stream rd%0d rvalid", i), {31'b0, rvalid}, 32'h1);
      chk($sformatf("stream rd%0d dout", i),   dout, 32'(i));
    end
    idle();
    step();
    chk("stream end rvalid", {31'b0, rvalid}, 32'h0);

    // ---- read-during-write modes on the 8-bit instances ----
    s_drive(1'b0, 1'b1, 4'd7, 1'b1, 8'h10);
    step();
    chk("m1 wr rvalid", {31'b0, m1_rvalid}, 32'h0);
    chk("m2 wr rvalid", {31'b0, m2_rvalid}, 32'h0);
    s_drive(1'b1, 1'b0, 4'd3, 1'b0, 8'h00);
    step();
    chk("m1 rd3 dout", {24'b0, m1_dout}, 32'h0);
    chk("m2 rd3 dout", {24'b0, m2_dout}, 32'h0);
    chk("m2 rd3 rvalid", {31'b0, m2_rvalid}, 32'h1);
    s_drive(1'b1, 1'b1, 4'd7, 1'b1, 8'h20);
    step();
    chk("wrfirst rmw dout",    {24'b0, m1_dout}, 32'h20);
    chk("wrfirst rmw rvalid",  {31'b0, m1_rvalid}, 32'h1);
    chk("nochange rmw dout",   {24'b0, m2_dout}, 32'h0);
    chk("nochange rmw rvalid", {31'b0, m2_rvalid}, 32'h0);
    chk("nochange rmw err",    {31'b0, m2_err}, 32'h0);
    chk("rdfirst8 rmw dout",   {24'b0, m3_dout}, 32'h10);
    s_drive(1'b1, 1'b0, 4'd7, 1'b0, 8'h00);
    step();
    chk("wrfirst follow-up",  {24'b0, m1_dout}, 32'h20);
    chk("nochange follow-up", {24'b0, m2_dout}, 32'h20);
    chk("rdfirst8 follow-up", {24'b0, m3_dout}, 32'h20);
    s_drive(1'b1, 1'b1, 4'd7, 1'b0, 8'h55);
    step();
    chk("wrfirst be0 rmw dout",   {24'b0, m1_dout}, 32'h20);
    chk("wrfirst be0 rmw rvalid", {31'b0, m1_rvalid}, 32'h1);
    chk("wrfirst be0 rmw err",    {31'b0, m1_err}, 32'h0);
    s_drive(1'b1, 1'b0, 4'd7, 1'b0, 8'h00);
    step();
    chk("wrfirst be0 unchanged", {24'b0, m1_dout}, 32'h20);
    s_cs = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sp_ram_sync.md
Name: sp_ram_sync

Overview:
- Parametrised synchronous single-port RAM. It is the next generation of the team's asynchronous 1Kx8 single-port RAM.
- Adds the following over that RAM:
  - width/depth generics
  - byte-enabled writes
  - registered read with a valid strobe
  - selectable read-during-write mode
  - hardware clear-on-reset sequencer with busy flag
  - error strobe
- Sits behind CPU/DMA-side bus logic as general scratch storage. Separate din/dout replace the tri-state bus; any bidirectional pad stays at the top level.

Parameters:
- DATA_W, 8: data width in bits; must be a multiple of 8.
- ADDR_W, 10: address width.
- DEPTH, 1024: number of words; must be ≤ 2**ADDR_W.
- READ_MODE, 0: read-during-write behaviour. 0 = read-first (old data), 1 = write-first (new data), 2 = no-change.
- CLEAR_ON_RESET, 1: 1 = zero the whole array after reset; 0 = skip the clear.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset; asynchronous, active-high.
- cs, input, 1: chip select.
- rd, input, 1: read request (qualified by cs).
- wr, input, 1: write request (qualified by cs).
- addr, input, ADDR_W: word address.
- be, input, DATA_W/8: byte enables for writes; bit i enables byte i.
- din, input, DATA_W: write data.
- dout, output, DATA_W: registered read data.
- rvalid, output, 1: dout updated this cycle (1-cycle pulse).
- busy, output, 1: clear sequence in progress; accesses are refused.
- err, output, 1: 1-cycle pulse on a refused access.

Behaviour:
- Reset (async assert, sync release):
  - dout = 0, rvalid = 0, err = 0.
  - state = CLEAR with clr_addr = 0 and busy = 1, if CLEAR_ON_RESET = 1.
  - Otherwise state = READY and busy = 0.
- FSM states: CLEAR, READY.
  - CLEAR: each clock writes 0 to mem[clr_addr], then clr_addr++.
  - When clr_addr == DEPTH-1, that word is written and the next state is READY.
  - busy is high for exactly DEPTH cycles after rst deasserts; busy = (state == CLEAR).
  - rst asserted mid-clear restarts from clr_addr = 0.
- Access evaluation (READY only, on the rising edge with cs = 1):
  - wr=1, rd=0: for each i with be[i] = 1, mem[addr] byte i = din byte i. rvalid = 0; dout holds.
  - rd=1, wr=0: dout = mem[addr] one clock later. rvalid = 1 in that cycle. Read latency is 1.
  - rd=1, wr=1 (read-modify-write cycle): the byte-enabled write is always performed. Output depends on READ_MODE:
    - 0: dout = pre-write word, rvalid = 1.
    - 1: dout = post-write merged word, rvalid = 1.
    - 2: dout holds, rvalid = 0.
  - rd=0, wr=0, or cs=0: no access; dout holds; rvalid = 0.
- Refused access:
  - Condition: cs & (rd | wr), and either busy = 1 or addr ≥ DEPTH.
  - Result: no memory change, dout holds, rvalid = 0, err = 1 for one cycle.
  - Back-to-back refused accesses give err high on consecutive cycles.
- be = 0 on a write: legal no-op. No err is raised, and any read part still completes.
- Back-to-back accesses: one per clock, full throughput, no bubbles. A read of an address written the previous cycle returns the new data.
- rvalid and err are never high in the same cycle.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Package ram_pkg holds:
  - localparams RD_FIRST = 0, WR_FIRST = 1, NO_CHANGE = 2
  - FSM state encoding: CLEAR, READY (1 bit)
  - the function deriving BE_W = DATA_W/8
- Sub-module ram_init_seq contains the CLEAR/READY FSM, the clr_addr counter and busy. It drives the array's internal write port mux.
- The top level holds the array, the byte-merge logic, the read register and the error logic.

Test Plan:
- Clear: rst pulse, CLEAR_ON_RESET = 1, DEPTH = 1024 → busy high for exactly 1024 cycles. Reading any of addr 0, 511 or 1023 afterwards gives dout = 0 and rvalid = 1 one cycle after the request.
- Byte write, DATA_W = 32: write 0xAABBCCDD at addr 5 with be = 4'b1111, then 0x11223344 with be = 4'b0101 → read returns 0xAA22CC44.
- RMW: addr 7 holds 0x10; cycle with rd = wr = 1, din = 0x20 → dout = 0x10 (mode 0), 0x20 (mode 1), or held with rvalid = 0 (mode 2). A follow-up read returns 0x20 in every mode.
- Refused: access issued during busy, and access with DEPTH = 1000, addr = 1000 → err pulses 1 cycle, rvalid = 0, target memory unchanged.
- Reset mid-clear: assert rst at clear cycle 300 → busy stays high for a further DEPTH cycles from rst release. Word 299 reads 0.
- Streaming: writes to addr 0..15 back-to-back with data = addr, then reads back-to-back → rvalid high 16 consecutive cycles, dout = 0..15 in order.
